// File: rtl/gate_bist_checker.sv
// rtl/gate_bist_checker.sv - walks every input vector into a gate and checks its output against a truth table
// Optional macro GATE_BIST_STOP_ON_FAIL_EN: the first mismatch ends the run.
module gate_bist_checker #(
   parameter int N_IN   = 2,
   parameter int SETTLE = 2,
   parameter int ERR_W  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2**N_IN-1:0]   truth_tbl,
   output logic [N_IN-1:0]      dut_in,
   input  logic                 dut_out,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [ERR_W-1:0]     err_cnt,
   output logic                 first_fail_vld,
   output logic [N_IN-1:0]      first_fail_vec
);

   localparam int              NV       = 2**N_IN;
   localparam logic [7:0]      SETTLE_C = 8'(SETTLE);
   localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_nxt;
   logic [NV-1:0]     tbl, tbl_nxt;
   logic [N_IN-1:0]   vec, vec_nxt;
   logic [7:0]        cnt, cnt_nxt;
   logic [ERR_W-1:0]  err_nxt;
   logic              ffv_nxt;
   logic [N_IN-1:0]   ffvec_nxt;
   logic              busy_nxt, done_nxt;
   logic              sample, mismatch, stop;

   // vec is parked at zero outside RUN, so it drives the gate directly
   assign dut_in   = vec;
   assign sample   = (cnt == SETTLE_C);
   assign mismatch = (dut_out != tbl[vec]);
   assign pass     = done && (err_cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         tbl            <= '0;
         vec            <= '0;
         cnt            <= '0;
         err_cnt        <= '0;
         first_fail_vld <= 1'b0;
         first_fail_vec <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         state          <= state_nxt;
         tbl            <= tbl_nxt;
         vec            <= vec_nxt;
         cnt            <= cnt_nxt;
         err_cnt        <= err_nxt;
         first_fail_vld <= ffv_nxt;
         first_fail_vec <= ffvec_nxt;
         busy           <= busy_nxt;
         done           <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tbl_nxt   = tbl;
      vec_nxt   = vec;
      cnt_nxt   = cnt;
      err_nxt   = err_cnt;
      ffv_nxt   = first_fail_vld;
      ffvec_nxt = first_fail_vec;
      busy_nxt  = busy;
      done_nxt  = done;
      stop      = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = RUN;
               tbl_nxt   = truth_tbl;
               vec_nxt   = '0;
               cnt_nxt   = '0;
               err_nxt   = '0;
               ffv_nxt   = 1'b0;
               ffvec_nxt = '0;
               busy_nxt  = 1'b1;
               done_nxt  = 1'b0;
            end
         end
         RUN: begin
            if (!sample) begin
               cnt_nxt = cnt + 8'd1;
            end else begin
               if (mismatch) begin
                  err_nxt = (err_cnt == ERR_MAX) ? err_cnt : err_cnt + 1'b1;
                  if (!first_fail_vld) begin
                     ffv_nxt   = 1'b1;
                     ffvec_nxt = vec;
                  end
               end
               stop = (vec == VEC_LAST);
`ifdef GATE_BIST_STOP_ON_FAIL_EN
               stop = stop || mismatch;
`else
               stop = stop || 1'b0;
`endif
               cnt_nxt = '0;
               if (stop) begin
                  state_nxt = DONE;
                  vec_nxt   = '0;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
               end else begin
                  vec_nxt = vec + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_gate_bist_checker.sv
// tb/tb_gate_bist_checker.sv - directed and randomized checks of gate_bist_checker against a truth-table model
module tb_gate_bist_checker;

   localparam int SETTLE = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] truth_tbl;
   logic [1:0] dut_in;
   logic       dut_out;
   logic       busy, done, pass, first_fail_vld;
   logic [3:0] err_cnt;
   logic [1:0] first_fail_vec;
   logic [3:0] gate_tbl;

   logic       s_start;
   logic [7:0] s_tbl;
   logic [2:0] s_dut_in;
   logic       s_out;
   logic       s_busy, s_done, s_pass, s_ffv;
   logic [1:0] s_err;
   logic [2:0] s_ffvec;

   int total    = 0;
   int pass_cnt = 0;
   int fail_cnt = 0;

   always #5 clk = ~clk;

   // gate under test: arbitrary 2-input function given by gate_tbl
   assign dut_out = gate_tbl[dut_in];

   gate_bist_checker #(.N_IN(2), .SETTLE(SETTLE), .ERR_W(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .truth_tbl(truth_tbl),
      .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
      .err_cnt(err_cnt), .first_fail_vld(first_fail_vld), .first_fail_vec(first_fail_vec)
   );

   gate_bist_checker #(.N_IN(3), .SETTLE(SETTLE), .ERR_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .start(s_start), .truth_tbl(s_tbl),
      .dut_in(s_dut_in), .dut_out(s_out), .busy(s_busy), .done(s_done), .pass(s_pass),
      .err_cnt(s_err), .first_fail_vld(s_ffv), .first_fail_vec(s_ffvec)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model: every vector gets SETTLE+1 cycles; errors are the differing table bits.
   task automatic run_test(input string tag, input logic [3:0] tbl, input logic [3:0] gate,
                           input bit mid_start);
      int  n;
      int  exp_err, exp_first, exp_cyc;
      bit  found, seq_ok;
      logic [1:0] exp_vec;
      exp_err = 0; exp_first = 0; found = 0;
      for (int i = 0; i < 4; i++) begin
         if (tbl[i] != gate[i]) begin
            if (!found) begin found = 1; exp_first = i; end
            exp_err++;
         end
      end
      exp_cyc = 4 * (SETTLE + 1);
`ifdef GATE_BIST_STOP_ON_FAIL_EN
      if (found) begin exp_err = 1; exp_cyc = (exp_first + 1) * (SETTLE + 1); end
`endif
      @(negedge clk);
      truth_tbl = tbl; gate_tbl = gate; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, " busy_at_start"}, busy, 1);
      check({tag, " err_cleared"}, {first_fail_vld, err_cnt}, 0);
      n = 0; seq_ok = 1;
      while (!done && n < 200) begin
         exp_vec = 2'(n / (SETTLE + 1));
         if (dut_in !== exp_vec) seq_ok = 0;
         @(negedge clk);
         n++;
         start = (mid_start && n == 5 && !done);
         if (mid_start && n == 5) truth_tbl = ~tbl;
      end
      start = 1'b0;
      check({tag, " vec_sequence"}, seq_ok, 1);
      check({tag, " cycles"}, n, exp_cyc);
      check({tag, " done_busy"}, {done, busy}, 2'b10);
      check({tag, " dut_in_idle"}, dut_in, 0);
      check({tag, " err_cnt"}, err_cnt, exp_err);
      check({tag, " ff_vld"}, first_fail_vld, found);
      check({tag, " ff_vec"}, first_fail_vec, found ? exp_first : 0);
      check({tag, " pass"}, pass, exp_err == 0);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; start = 1'b0; truth_tbl = '0; gate_tbl = 4'b1000;
      s_start = 1'b0; s_tbl = '0; s_out = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {busy, done, pass, err_cnt, first_fail_vld, first_fail_vec, dut_in}, 0);
      check("reset_sat_outputs", {s_busy, s_done, s_pass, s_err, s_ffv, s_ffvec, s_dut_in}, 0);
      rst_n = 1'b1;

      run_test("and_good", 4'b1000, 4'b1000, 0);
      run_test("or_bad", 4'b1000, 4'b1110, 0);
      run_test("restart_good", 4'b1000, 4'b1000, 0);
      run_test("mid_start_ignored", 4'b1000, 4'b1000, 1);

      // saturation: stuck-at-1 gate, 3 inputs, 2-bit counter
      @(negedge clk);
      s_tbl = 8'h80; s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      n = 0;
      while (!s_done && n < 200) begin @(negedge clk); n++; end
`ifdef GATE_BIST_STOP_ON_FAIL_EN
      check("sat_cycles", n, 3);
      check("sat_err", s_err, 1);
`else
      check("sat_cycles", n, 24);
      check("sat_err", s_err, 3);
`endif
      check("sat_ff", {s_ffv, s_ffvec}, 4'b1000);
      check("sat_pass", s_pass, 0);

      // asynchronous reset in the middle of a failing run
      @(negedge clk);
      truth_tbl = 4'b1000; gate_tbl = 4'b1110; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      check("pre_reset_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1 check("async_reset_outputs",
               {busy, done, pass, err_cnt, first_fail_vld, first_fail_vec, dut_in}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_after_reset", {busy, done, dut_in}, 0);
      run_test("after_reset", 4'b1000, 4'b1000, 0);

      for (int k = 0; k < 8; k++) begin
         run_test($sformatf("rand%0d", k), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0);
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
